seg_scan_ctrl: RTL and testbench

//  Parametrised, bus-writable multiplexed 7-segment display controller.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam logic [1:0] ADDR_DATA_LO = 2'd0;
    localparam logic [1:0] ADDR_DATA_HI = 2'd1;
    localparam logic [1:0] ADDR_DP_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_LZ_BIT = 1;

    // Active-low glyphs, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (nibble)
            4'h0: seg_c = GLYPH_0;
            4'h1: seg_c = GLYPH_1;
            4'h2: seg_c = GLYPH_2;
            4'h3: seg_c = GLYPH_3;
            4'h4: seg_c = GLYPH_4;
            4'h5: seg_c = GLYPH_5;
            4'h6: seg_c = GLYPH_6;
            4'h7: seg_c = GLYPH_7;
            4'h8: seg_c = GLYPH_8;
            4'h9: seg_c = GLYPH_9;
            4'hA: seg_c = GLYPH_A;
            4'hB: seg_c = GLYPH_B;
            4'hC: seg_c = GLYPH_C;
            4'hD: seg_c = GLYPH_D;
            4'hE: seg_c = GLYPH_E;
            4'hF: seg_c = GLYPH_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Bus-writable multiplexed 7-segment controller with frame-buffered digit data.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_sel,
    output logic                  frame_tick
);
    import seg_pkg::*;

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);

    logic [DW-1:0]         pend_data, shad_data, data_next, upper;
    logic [NUM_DIGITS-1:0] pend_dp, shad_dp, sel_next;
    logic [1:0]            ctrl;
    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [63:0]           pend_wide, write_wide;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic                  wr, enable, blank, dp_on, frame_wrap;
    logic                  unused_bits;

    assign wr         = cs && we;
    assign enable     = ctrl[CTRL_EN_BIT];
    assign frame_wrap = enable && (pre == LAST_PRE) && (idx == LAST_IDX);

    // Digit data viewed as a 64-bit LO/HI pair; bits beyond the digit count drop out
    always_comb begin
        pend_wide  = 64'(pend_data);
        write_wide = pend_wide;
        if (addr == ADDR_DATA_HI) write_wide[63:32] = wdata;
        else                      write_wide[31:0]  = wdata;
        data_next  = write_wide[DW-1:0];
    end

    assign unused_bits = ^write_wide;

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_DATA_LO: rdata = pend_wide[31:0];
            ADDR_DATA_HI: rdata = pend_wide[63:32];
            ADDR_DP_MASK: rdata = 32'(pend_dp);
            ADDR_CTRL:    rdata = 32'(ctrl);
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            ctrl      <= 2'b01;
        end else if (wr) begin
            case (addr)
                ADDR_DATA_LO, ADDR_DATA_HI: pend_data <= data_next;
                ADDR_DP_MASK:               pend_dp   <= wdata[NUM_DIGITS-1:0];
                ADDR_CTRL:                  ctrl      <= wdata[1:0];
                default:                    ;
            endcase
        end
    end

    // Prescaler, digit index and frame-boundary shadow capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            shad_data  <= '0;
            shad_dp    <= '0;
        end else begin
            frame_tick <= frame_wrap;
            if (frame_wrap) begin
                shad_data <= pend_data;
                shad_dp   <= pend_dp;
            end
            if (!enable) begin
                pre <= '0;
                idx <= '0;
            end else if (pre == LAST_PRE) begin
                pre <= '0;
                idx <= (idx == LAST_IDX) ? '0 : IW'(idx + 1'b1);
            end else begin
                pre <= PW'(pre + 1'b1);
            end
        end
    end

    assign nibble   = shad_data[{idx, 2'b00} +: 4];
    assign upper    = shad_data >> {idx, 2'b00};
    assign blank    = ctrl[CTRL_LZ_BIT] && (idx != '0) && (upper == '0);
    assign dp_on    = shad_dp[idx];
    assign sel_next = ~(NUM_DIGITS'(1) << idx);

    seg_hex_decode u_decode (
        .nibble (nibble),
        .seg_c  (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_seg <= 8'hFF;
            o_sel <= '1;
        end else if (!enable) begin
            o_seg <= 8'hFF;
            o_sel <= '1;
        end else begin
            o_seg <= {~dp_on, blank ? SEG_OFF : glyph};
            o_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised and directed bench for seg_scan_ctrl (4 digits, 4-cycle dwell).
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset, cs, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  o_seg;
    logic [3:0]  o_sel;
    logic        frame_tick;

    seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .o_seg      (o_seg),
        .o_sel      (o_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what is pending, what is on display, and enabled cycles since scan start
    logic [15:0] m_pend, m_shad;
    logic [3:0]  m_dp_p, m_dp_s;
    logic [1:0]  m_ctrl;
    int          run;
    logic [7:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_tick;

    string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] s = 7'h7F;
        string g = glyph_str[v];
        for (int i = 0; i < g.len(); i++) s[int'(g[i]) - 97] = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_shad = '0; m_dp_p = '0; m_dp_s = '0;
        m_ctrl = 2'b01; run = 0;
        e_seg = 8'hFF; e_sel = 4'hF; e_tick = 1'b0;
    endtask

    // Advance the model across one rising edge using the pre-edge inputs
    task automatic model_step();
        int d;
        logic bl;
        if (m_ctrl[0]) begin
            d = (run / SD) % N;
            bl = m_ctrl[1] && (d > 0) && ((m_shad >> (4 * d)) == 16'h0);
            e_sel = ~(4'b0001 << d);
            e_seg = {~m_dp_s[d], bl ? 7'h7F : glyph(m_shad[4*d +: 4])};
            e_tick = (run % (SD * N)) == (SD * N - 1);
            run++;
        end else begin
            e_sel = 4'hF; e_seg = 8'hFF; e_tick = 1'b0; run = 0;
        end
        if (e_tick) begin
            m_shad = m_pend;
            m_dp_s = m_dp_p;
        end
        if (cs && we) begin
            case (addr)
                2'd0: m_pend = wdata[15:0];
                2'd2: m_dp_p = wdata[3:0];
                2'd3: m_ctrl = wdata[1:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        case (addr)
            2'd0: return 32'(m_pend);
            2'd2: return 32'(m_dp_p);
            2'd3: return 32'(m_ctrl);
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare();
        check("o_sel", 32'(o_sel), 32'(e_sel));
        check("o_seg", 32'(o_seg), 32'(e_seg));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
        check("rdata", rdata, exp_rdata());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 40 && frame_tick !== 1'b1; k++) tick();
        check("frame_tick_wait", 32'(frame_tick), 32'h1);
    endtask

    task automatic wait_digit(input int d);
        logic [3:0] want = ~(4'b0001 << d);
        for (int k = 0; k < 40 && o_sel !== want; k++) tick();
        check("digit_wait", 32'(o_sel), 32'(want));
    endtask

    initial begin
        int len;
        logic [3:0] s;
        reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare();
        check("rst_seg", 32'(o_seg), 32'hFF);
        check("rst_sel", 32'(o_sel), 32'hF);
        reset = 1'b0;
        tick();
        check("first_sel", 32'(o_sel), 32'hE);
        check("first_seg", 32'(o_seg), 32'hC0);

        // Mid-frame write stays hidden until the next frame boundary
        repeat (5) tick();
        bus_write(2'd0, 32'h1234);
        wait_frame();
        wait_digit(0);
        check("d0_1234", 32'(o_seg), 32'h99);
        wait_digit(3);
        check("d3_1234", 32'(o_seg), 32'hF9);

        // Dwell per digit and frame period
        for (int r = 0; r < 3; r++) begin
            s = o_sel;
            for (int k = 0; k < 20 && o_sel === s; k++) tick();
            s = o_sel; len = 0;
            for (int k = 0; k < 20 && o_sel === s; k++) begin tick(); len++; end
            check("dwell", 32'(len), 32'd4);
        end
        wait_frame();
        len = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); len++;
            if (frame_tick === 1'b1) break;
        end
        check("frame_period", 32'(len), 32'd16);

        // Leading-zero blanking
        bus_write(2'd3, 32'h3);
        bus_write(2'd0, 32'h0050);
        wait_frame();
        wait_digit(0); check("lz_d0", 32'(o_seg), 32'hC0);
        wait_digit(1); check("lz_d1", 32'(o_seg), 32'h92);
        wait_digit(2); check("lz_d2", 32'(o_seg), 32'hFF);
        wait_digit(3); check("lz_d3", 32'(o_seg), 32'hFF);

        // Decimal point mask
        bus_write(2'd2, 32'h2);
        wait_frame();
        wait_digit(0); check("dp_d0", 32'(o_seg[7]), 32'h1);
        wait_digit(1); check("dp_d1", 32'(o_seg[7]), 32'h0);
        wait_digit(2); check("dp_d2", 32'(o_seg[7]), 32'h1);

        // Write landing exactly on the frame-wrap edge is deferred one frame
        wait_frame();
        repeat (15) tick();
        bus_write(2'd0, 32'h0007);
        wait_digit(0); check("wrap_old", 32'(o_seg), 32'hC0);
        wait_frame();
        wait_digit(0); check("wrap_new", 32'(o_seg), 32'hF8);

        // Random bus traffic, including enable/lz toggles
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 9) < 2) begin
                cs = 1'b1; we = 1'b1;
                addr = 2'($urandom_range(0, 3));
                wdata = $urandom >> $urandom_range(0, 31);
                if (addr == 2'd3 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            end else begin
                cs = 1'($urandom_range(0, 1)); we = 1'b0;
                addr = 2'($urandom_range(0, 3));
                wdata = $urandom;
            end
            tick();
        end
        cs = 1'b0; we = 1'b0;

        // Disable, re-enable, then asynchronous reset mid-frame
        bus_write(2'd3, 32'h1);
        repeat (5) tick();
        bus_write(2'd3, 32'h0);
        tick();
        check("dis_sel", 32'(o_sel), 32'hF);
        check("dis_seg", 32'(o_seg), 32'hFF);
        repeat (3) tick();
        bus_write(2'd3, 32'h1);
        repeat (22) tick();
        bus_write(2'd0, 32'hABCD);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("arst_sel", 32'(o_sel), 32'hF);
        check("arst_seg", 32'(o_seg), 32'hFF);
        check("arst_tick", 32'(frame_tick), 32'h0);
        model_reset();
        addr = 2'd0;
        #1;
        check("arst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
